// File: rtl/rotor_master.sv
// rtl/rotor_master.sv - three-rotor position register with load, Enigma stepping and double step
// Positions are mod-ALPHABET counters; a load always beats a keypress in the same cycle.
module rotor_master #(
  parameter int ALPHABET      = 26,
  parameter int NOTCH_DREAPTA = 21,
  parameter int NOTCH_MIJLOC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pozitie_rotor_in,
  input  logic [4:0] pozitie_initiala_in,
  input  logic       step_in,
  output logic [4:0] pozitie_stanga_out,
  output logic [4:0] pozitie_mijloc_out,
  output logic [4:0] pozitie_dreapta_out,
  output logic       err_out
);

  localparam logic [4:0] LAST       = 5'(ALPHABET - 1);
  localparam logic [4:0] NOTCH_R    = 5'(NOTCH_DREAPTA);
  localparam logic [4:0] NOTCH_M    = 5'(NOTCH_MIJLOC);
  localparam logic [5:0] ALPHA_SIZE = 6'(ALPHABET);

  logic [4:0] stanga, mijloc, dreapta;
  logic [4:0] stanga_next, mijloc_next, dreapta_next;
  logic       err, err_next;
  logic       load, valid;

  function automatic logic [4:0] advance(input logic [4:0] x);
    return (x == LAST) ? 5'd0 : x + 5'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stanga  <= 5'd0;
      mijloc  <= 5'd0;
      dreapta <= 5'd0;
      err     <= 1'b0;
    end else begin
      stanga  <= stanga_next;
      mijloc  <= mijloc_next;
      dreapta <= dreapta_next;
      err     <= err_next;
    end
  end

  always_comb begin
    load         = |pozitie_rotor_in;
    valid        = {1'b0, pozitie_initiala_in} < ALPHA_SIZE;
    stanga_next  = stanga;
    mijloc_next  = mijloc;
    dreapta_next = dreapta;
    err_next     = 1'b0;
    if (load) begin
      if (valid) begin
        case (pozitie_rotor_in)
          2'd1:    stanga_next  = pozitie_initiala_in;
          2'd2:    mijloc_next  = pozitie_initiala_in;
          2'd3:    dreapta_next = pozitie_initiala_in;
          default: ;
        endcase
      end else begin
        err_next = 1'b1;
      end
    end else if (step_in) begin
      // The middle rotor sitting on its own notch steps itself again (double step).
      dreapta_next = advance(dreapta);
      if (dreapta == NOTCH_R || mijloc == NOTCH_M)
        mijloc_next = advance(mijloc);
      if (mijloc == NOTCH_M)
        stanga_next = advance(stanga);
    end
  end

  assign pozitie_stanga_out  = stanga;
  assign pozitie_mijloc_out  = mijloc;
  assign pozitie_dreapta_out = dreapta;
  assign err_out             = err;

endmodule

// File: tb/tb_rotor_master.sv
// tb/tb_rotor_master.sv - randomized and directed bench for rotor_master against an arithmetic model
module tb_rotor_master;

  logic       clk;
  logic       rst;
  logic [1:0] pozitie_rotor_in;
  logic [4:0] pozitie_initiala_in;
  logic       step_in;
  logic [4:0] pozitie_stanga_out;
  logic [4:0] pozitie_mijloc_out;
  logic [4:0] pozitie_dreapta_out;
  logic       err_out;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: positions as plain integers indexed 1=left, 2=middle, 3=right.
  int pos[1:3];
  int err_exp;

  rotor_master dut (
    .clk                 (clk),
    .rst                 (rst),
    .pozitie_rotor_in    (pozitie_rotor_in),
    .pozitie_initiala_in (pozitie_initiala_in),
    .step_in             (step_in),
    .pozitie_stanga_out  (pozitie_stanga_out),
    .pozitie_mijloc_out  (pozitie_mijloc_out),
    .pozitie_dreapta_out (pozitie_dreapta_out),
    .err_out             (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_left"},  int'(pozitie_stanga_out),  pos[1]);
    check({tag, "_mid"},   int'(pozitie_mijloc_out),  pos[2]);
    check({tag, "_right"}, int'(pozitie_dreapta_out), pos[3]);
    check({tag, "_err"},   int'(err_out),             err_exp);
  endtask

  task automatic model_edge(input int sel, input int val, input int stp);
    int l, m, r;
    l = pos[1]; m = pos[2]; r = pos[3];
    err_exp = 0;
    if (sel != 0) begin
      if (val < 26) pos[sel] = val;
      else err_exp = 1;
    end else if (stp != 0) begin
      pos[3] = (r + 1) % 26;
      if (r == 21 || m == 4) pos[2] = (m + 1) % 26;
      if (m == 4) pos[1] = (l + 1) % 26;
    end
  endtask

  task automatic cycle(input int sel, input int val, input int stp, input string tag);
    pozitie_rotor_in    = 2'(sel);
    pozitie_initiala_in = 5'(val);
    step_in             = stp[0];
    @(posedge clk);
    model_edge(sel, val, stp);
    #1;
    check_all(tag);
  endtask

  task automatic load3(input int l, input int m, input int r);
    cycle(1, l, 0, "ld_l");
    cycle(2, m, 0, "ld_m");
    cycle(3, r, 0, "ld_r");
  endtask

  initial begin
    rst = 1'b0;
    pozitie_rotor_in    = 2'd3;
    pozitie_initiala_in = 5'd0;
    step_in             = 1'b0;
    pos[1] = 0; pos[2] = 0; pos[3] = 0; err_exp = 0;
    #23;
    check_all("reset");
    @(negedge clk);
    pozitie_rotor_in = 2'd0;
    rst = 1'b1;
    cycle(0, 0, 0, "idle0");
    cycle(0, 0, 0, "idle1");

    cycle(1, 9, 0, "load_l9");
    check("left_is_9", int'(pozitie_stanga_out), 9);
    cycle(1, 13, 0, "load_l13");
    check("left_is_13", int'(pozitie_stanga_out), 13);
    cycle(2, 13, 0, "load_m13");
    cycle(2, 0, 0, "load_m0");
    cycle(2, 3, 0, "load_m3");
    check("mid_is_3", int'(pozitie_mijloc_out), 3);
    check("right_still_0", int'(pozitie_dreapta_out), 0);

    cycle(3, 27, 0, "bad_load");
    check("err_pulse", int'(err_out), 1);
    cycle(0, 0, 0, "after_bad");
    check("err_cleared", int'(err_out), 0);
    cycle(3, 25, 0, "edge_25");
    cycle(3, 26, 1, "bad_26_step");

    load3(0, 0, 20);
    cycle(0, 0, 1, "carry1");
    check("carry1_m", int'(pozitie_mijloc_out), 0);
    cycle(0, 0, 1, "carry2");
    check("carry2_m", int'(pozitie_mijloc_out), 1);
    cycle(0, 0, 1, "carry3");
    check("carry3_r", int'(pozitie_dreapta_out), 23);

    load3(0, 3, 21);
    cycle(0, 0, 1, "dbl1");
    check("dbl1_m", int'(pozitie_mijloc_out), 4);
    cycle(0, 0, 1, "dbl2");
    check("dbl2_l", int'(pozitie_stanga_out), 1);
    check("dbl2_m", int'(pozitie_mijloc_out), 5);
    cycle(0, 0, 1, "dbl3");
    check("dbl3_r", int'(pozitie_dreapta_out), 24);

    load3(25, 25, 25);
    cycle(0, 0, 1, "wrap");
    check("wrap_r", int'(pozitie_dreapta_out), 0);
    cycle(3, 7, 1, "prio");
    check("prio_r", int'(pozitie_dreapta_out), 7);

    for (int i = 0; i < 400; i++) begin
      int sel, val, stp;
      sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      val = ($urandom_range(0, 4) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
      stp = int'($urandom_range(0, 1));
      cycle(sel, val, stp, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rotor_master.md
Name: rotor_master

Overview:
- Position controller for the three rotors of the Enigma-style cipher datapath.
- Holds the current letter position (0..25, A..Z) of the left, middle and right rotors.
- Loads initial positions one rotor at a time and advances the rotors on each keypress strobe, using Enigma stepping including the middle-rotor double step.
- Feeds the rotor wiring/permutation stages downstream.

Parameters:
- ALPHABET, 26, number of positions per rotor; positions are 0..ALPHABET-1.
- NOTCH_DREAPTA, 21, right-rotor position at which the middle rotor is carried (V).
- NOTCH_MIJLOC, 4, middle-rotor position at which the left rotor is carried and the middle rotor double-steps (E).

Ports:
- clk  in  1  system clock, all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pozitie_rotor_in  in  2  load select: 0 none, 1 left, 2 middle, 3 right.
- pozitie_initiala_in  in  5  initial position value to load into the selected rotor.
- step_in  in  1  one-cycle keypress strobe; advances the rotors.
- pozitie_stanga_out  out  5  left rotor position.
- pozitie_mijloc_out  out  5  middle rotor position.
- pozitie_dreapta_out  out  5  right rotor position.
- err_out  out  1  one-cycle pulse when a load value is out of range.

Behaviour:
- Reset (rst=0, asynchronous):
  - all three positions go to 0 and err_out goes to 0.
  - Reset held low overrides every input.
  - Release is taken at the next clock edge.
- Registered outputs: each output is a direct copy of its position register.
- Load:
  - Every rising edge with pozitie_rotor_in != 0 is a load.
  - If pozitie_initiala_in < ALPHABET, the selected rotor register takes the value at that edge.
  - Other rotors are unchanged.
  - The select level is sampled each cycle; holding it loads repeatedly, and value changes while held are tracked with 1-cycle latency.
- Invalid load:
  - Applies when pozitie_rotor_in != 0 and pozitie_initiala_in >= ALPHABET (26..31).
  - No register changes.
  - err_out = 1 for the following cycle only; it is recomputed every cycle.
- Load priority: if a load (valid or invalid) and step_in occur in the same cycle, the load wins and step_in is ignored for that cycle. No pending step is stored.
- Step (step_in=1, no load), evaluated on pre-step values:
  - Right rotor always advances by 1.
  - Middle rotor advances by 1 if right == NOTCH_DREAPTA or middle == NOTCH_MIJLOC (double step).
  - Left rotor advances by 1 if middle == NOTCH_MIJLOC.
- Wrap-around: advancing from ALPHABET-1 gives 0. Arithmetic is mod ALPHABET, 5-bit, never exceeding 25.
- Idle: no load and no step leaves all registers unchanged.
- step_in is level-sampled: holding it high steps once per clock.

Test Plan:
- Reset and hold: rst=0 with select=3, value=0, then rst=1 -> all positions 0 and err_out 0; after release with no step, outputs stay 0.
- Load sequence:
  - select=1 with value 9 -> left=9 next cycle.
  - Value changed to 13 while select held -> left=13.
  - select=2 -> middle=13.
  - Value 0 -> middle=0.
  - Value 3 -> middle=3.
  - Right stays 0 throughout.
- Invalid value: select=3, value=27 -> right unchanged, err_out=1 for exactly one cycle; err_out stays 0 on any valid load.
- Stepping and carry: load L=0, M=0, R=20, then three steps:
  - R=21, M=0.
  - R=22, M=1 (carry from notch).
  - R=23, M=1.
- Double step:
  - Load L=0, M=3, R=21.
  - Step -> M=4, R=22.
  - Step -> L=1, M=5, R=23.
  - Step -> L=1, M=5, R=24.
- Wrap and priority:
  - R=25, step -> R=0.
  - select=3 value 7 with step_in=1 in the same cycle -> R=7 and no rotor steps.
